// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order write queue feeding the register file's single write port.
// Merges MEM/WB writes and long-latency unit results, drains one entry per cycle and
// offers forwarding lookups of queued-but-uncommitted results to ID.
// Optional feature macro: WBQ_FWD_EN (defined: forwarding lookups active;
// undefined: fwd_hit*/fwd_data* tied to zero).
module wb_write_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              lng_valid,
  input  logic [ADDR_W-1:0] lng_waddr,
  input  logic [DATA_W-1:0] lng_wdata,
  output logic              lng_ready,
  output logic              stall_req,
  input  logic [ADDR_W-1:0] fwd_raddr1,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data1,
  input  logic [ADDR_W-1:0] fwd_raddr2,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data2,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0] DepthS = (CntW + 1)'(DEPTH);
  localparam logic [CntW-1:0] StallLvl = CntW'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, lng_idx;
  logic [CntW-1:0] count_q, count_d, count_vis;
  logic [CntW:0]   space, need;
  logic            pipe_eff, pipe_enq, lng_enq, deq;

  // Enqueue/dequeue decisions and next pointer/count values.
  always_comb begin
    // Reset hides the queue immediately, even before the clearing edge.
    count_vis = rst ? '0 : count_q;
    pipe_eff  = pipe_we && (pipe_waddr != '0);
    // The head slot frees up this edge whenever the queue is non-empty.
    space     = DepthS - {1'b0, count_q} + {{CntW{1'b0}}, (count_q != '0)};
    need      = pipe_eff ? (CntW + 1)'(2) : (CntW + 1)'(1);
    lng_ready = !rst && (space >= need);
    // A pipe write with no space is a protocol violation and is dropped.
    pipe_enq  = !rst && pipe_eff && (space != '0);
    lng_enq   = lng_ready && lng_valid && (lng_waddr != '0);
    deq       = (count_q != '0);
    // Pipe entry lands first; lng entry goes behind it.
    lng_idx   = pipe_enq ? tail_q + PtrW'(1) : tail_q;
    head_d    = head_q + PtrW'(deq);
    tail_d    = tail_q + PtrW'(pipe_enq) + PtrW'(lng_enq);
    count_d   = count_q + CntW'(pipe_enq) + CntW'(lng_enq) - CntW'(deq);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; the two write slots never collide because lng_idx skips the pipe slot.
  always_ff @(posedge clk) begin
    if (pipe_enq) begin
      addr_q[tail_q] <= pipe_waddr;
      data_q[tail_q] <= pipe_wdata;
    end
    if (lng_enq) begin
      addr_q[lng_idx] <= lng_waddr;
      data_q[lng_idx] <= lng_wdata;
    end
  end

  // Register file port and status, driven from storage only.
  always_comb begin
    we        = (count_vis != '0);
    waddr     = we ? addr_q[head_q] : '0;
    wdata     = we ? data_q[head_q] : '0;
    empty     = (count_vis == '0);
    stall_req = (count_vis >= StallLvl);
  end

`ifdef WBQ_FWD_EN
  logic [PtrW-1:0] fwd_idx;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    fwd_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PtrW'(k);
      if (CntW'(k) < count_vis) begin
        if ((fwd_raddr1 != '0) && (addr_q[fwd_idx] == fwd_raddr1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_q[fwd_idx];
        end
        if ((fwd_raddr2 != '0) && (addr_q[fwd_idx] == fwd_raddr2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_q[fwd_idx];
        end
      end
    end
  end
`else
  logic unused_fwd;

  // Forwarding disabled: ID must stall on queued hazards externally.
  always_comb begin
    fwd_hit1   = 1'b0;
    fwd_data1  = '0;
    fwd_hit2   = 1'b0;
    fwd_data2  = '0;
    unused_fwd = ^{fwd_raddr1, fwd_raddr2};
  end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue (DEPTH=4, ADDR_W=5, DATA_W=32).
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lng_valid;
  logic [4:0]  lng_waddr;
  logic [31:0] lng_wdata;
  logic        lng_ready;
  logic        stall_req;
  logic [4:0]  fwd_raddr1;
  logic        fwd_hit1;
  logic [31:0] fwd_data1;
  logic [4:0]  fwd_raddr2;
  logic        fwd_hit2;
  logic [31:0] fwd_data2;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        empty;

  int checks = 0;
  int errors = 0;

  wb_write_queue #(
    .DEPTH (4),
    .ADDR_W(5),
    .DATA_W(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_waddr(pipe_waddr),
    .pipe_wdata(pipe_wdata),
    .lng_valid (lng_valid),
    .lng_waddr (lng_waddr),
    .lng_wdata (lng_wdata),
    .lng_ready (lng_ready),
    .stall_req (stall_req),
    .fwd_raddr1(fwd_raddr1),
    .fwd_hit1  (fwd_hit1),
    .fwd_data1 (fwd_data1),
    .fwd_raddr2(fwd_raddr2),
    .fwd_hit2  (fwd_hit2),
    .fwd_data2 (fwd_data2),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we    = 1'b0;
    pipe_waddr = '0;
    pipe_wdata = '0;
    lng_valid  = 1'b0;
    lng_waddr  = '0;
    lng_wdata  = '0;
  endtask

  task automatic test_reset();
    logic [39:0] exp;
    idle_inputs();
    fwd_raddr1 = 5'd4;
    fwd_raddr2 = 5'd0;
    rst        = 1'b1;
    lng_valid  = 1'b1;
    lng_waddr  = 5'd4;
    lng_wdata  = 32'h5;
    #1;
    checks++;
    if (lng_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_lng_ready got %b want 0", lng_ready);
    end
    tick();
    tick();
    exp = {1'b0, 5'd0, 32'd0, 1'b1, 1'b0};
    checks++;
    if ({we, waddr, wdata, empty, stall_req} !== exp) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", {we, waddr, wdata, empty, stall_req}, exp);
    end
    rst = 1'b0;
    idle_inputs();
    tick();
    checks++;
    if ({we, empty, stall_req, fwd_hit1, fwd_data1} !== {1'b0, 1'b1, 1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL post_reset got we=%b empty=%b stall=%b hit1=%b data1=%h", we, empty,
               stall_req, fwd_hit1, fwd_data1);
    end
  endtask

  task automatic test_single();
    pipe_we    = 1'b1;
    pipe_waddr = 5'd3;
    pipe_wdata = 32'h11;
    tick();
    idle_inputs();
    checks++;
    if ({we, waddr, wdata, empty} !== {1'b1, 5'd3, 32'h11, 1'b0}) begin
      errors++;
      $display("FAIL single_out got we=%b waddr=%0d wdata=%h empty=%b want 1/3/11/0", we, waddr,
               wdata, empty);
    end
    tick();
    checks++;
    if ({we, waddr, wdata, empty} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL single_drained got we=%b waddr=%0d wdata=%h empty=%b want 0/0/0/1", we,
               waddr, wdata, empty);
    end
  endtask

  task automatic test_dual();
    pipe_we    = 1'b1;
    pipe_waddr = 5'd5;
    pipe_wdata = 32'hA;
    lng_valid  = 1'b1;
    lng_waddr  = 5'd6;
    lng_wdata  = 32'hB;
    #1;
    checks++;
    if (lng_ready !== 1'b1) begin
      errors++;
      $display("FAIL dual_ready got %b want 1", lng_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if ({we, waddr, wdata} !== {1'b1, 5'd5, 32'hA}) begin
      errors++;
      $display("FAIL dual_first got we=%b waddr=%0d wdata=%h want 1/5/a", we, waddr, wdata);
    end
    tick();
    checks++;
    if ({we, waddr, wdata} !== {1'b1, 5'd6, 32'hB}) begin
      errors++;
      $display("FAIL dual_second got we=%b waddr=%0d wdata=%h want 1/6/b", we, waddr, wdata);
    end
    tick();
    checks++;
    if ({we, empty} !== 2'b01) begin
      errors++;
      $display("FAIL dual_drained got we=%b empty=%b want 0/1", we, empty);
    end
  endtask

  task automatic test_filter();
    pipe_we    = 1'b1;
    pipe_waddr = 5'd0;
    pipe_wdata = 32'hFF;
    lng_valid  = 1'b1;
    lng_waddr  = 5'd0;
    lng_wdata  = 32'h77;
    #1;
    checks++;
    if (lng_ready !== 1'b1) begin
      errors++;
      $display("FAIL filter_ready got %b want 1", lng_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if ({we, empty, waddr, wdata} !== {1'b0, 1'b1, 5'd0, 32'd0}) begin
      errors++;
      $display("FAIL filter_nothing got we=%b empty=%b waddr=%0d wdata=%h want 0/1/0/0", we,
               empty, waddr, wdata);
    end
  endtask

  task automatic test_full();
    logic [4:0] exp_a [5];
    logic [31:0] exp_d [5];
    exp_a = '{5'd9, 5'd10, 5'd11, 5'd12, 5'd0};
    exp_d = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd0};
    // Two enqueues per cycle to outrun the one-per-cycle drain.
    pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'd1;
    lng_valid = 1'b1; lng_waddr = 5'd2; lng_wdata = 32'd2;
    tick();
    checks++;
    if ({stall_req, waddr, wdata} !== {1'b0, 5'd1, 32'd1}) begin
      errors++;
      $display("FAIL full_c2 got stall=%b waddr=%0d wdata=%h want 0/1/1", stall_req, waddr, wdata);
    end
    pipe_waddr = 5'd7; pipe_wdata = 32'd3;
    lng_waddr = 5'd8; lng_wdata = 32'd4;
    tick();
    checks++;
    if ({stall_req, waddr, wdata} !== {1'b1, 5'd2, 32'd2}) begin
      errors++;
      $display("FAIL full_c3 got stall=%b waddr=%0d wdata=%h want 1/2/2", stall_req, waddr, wdata);
    end
    pipe_waddr = 5'd9; pipe_wdata = 32'd5;
    lng_waddr = 5'd10; lng_wdata = 32'd6;
    #1;
    checks++;
    if (lng_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_c3 got %b want 1", lng_ready);
    end
    tick();
    checks++;
    if ({stall_req, waddr, wdata} !== {1'b1, 5'd7, 32'd3}) begin
      errors++;
      $display("FAIL full_c4 got stall=%b waddr=%0d wdata=%h want 1/7/3", stall_req, waddr, wdata);
    end
    // Queue is full: a pipe write takes the only freed slot, lng must wait.
    pipe_waddr = 5'd11; pipe_wdata = 32'd7;
    lng_waddr = 5'd12; lng_wdata = 32'd8;
    #1;
    checks++;
    if (lng_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_blocked got %b want 0", lng_ready);
    end
    tick();
    checks++;
    if ({stall_req, waddr, wdata} !== {1'b1, 5'd8, 32'd4}) begin
      errors++;
      $display("FAIL full_c5 got stall=%b waddr=%0d wdata=%h want 1/8/4", stall_req, waddr, wdata);
    end
    pipe_we = 1'b0;
    #1;
    checks++;
    if (lng_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_reready got %b want 1", lng_ready);
    end
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({we, waddr, wdata} !== {(i < 4), exp_a[i], exp_d[i]}) begin
        errors++;
        $display("FAIL full_drain%0d got we=%b waddr=%0d wdata=%h want %b/%0d/%h", i, we, waddr,
                 wdata, (i < 4), exp_a[i], exp_d[i]);
      end
      tick();
    end
  endtask

  task automatic test_fwd();
    logic        exp_hit;
    logic [31:0] exp_data;
`ifdef WBQ_FWD_EN
    exp_hit  = 1'b1;
    exp_data = 32'h2;
`else
    exp_hit  = 1'b0;
    exp_data = 32'h0;
`endif
    pipe_we = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'h1;
    lng_valid = 1'b1; lng_waddr = 5'd9; lng_wdata = 32'h2;
    fwd_raddr1 = 5'd9;
    fwd_raddr2 = 5'd0;
    #1;
    checks++;
    if ({fwd_hit1, fwd_data1} !== {1'b0, 32'd0}) begin
      errors++;
      $display("FAIL fwd_same_cycle got hit=%b data=%h want 0/0", fwd_hit1, fwd_data1);
    end
    tick();
    idle_inputs();
    checks++;
    if ({fwd_hit1, fwd_data1} !== {exp_hit, exp_data}) begin
      errors++;
      $display("FAIL fwd_youngest got hit=%b data=%h want %b/%h", fwd_hit1, fwd_data1, exp_hit,
               exp_data);
    end
    checks++;
    if ({fwd_hit2, fwd_data2} !== {1'b0, 32'd0}) begin
      errors++;
      $display("FAIL fwd_r0 got hit=%b data=%h want 0/0", fwd_hit2, fwd_data2);
    end
    fwd_raddr2 = 5'd9;
    fwd_raddr1 = 5'd4;
    #1;
    checks++;
    if ({fwd_hit1, fwd_hit2, fwd_data2} !== {1'b0, exp_hit, exp_data}) begin
      errors++;
      $display("FAIL fwd_port2 got hit1=%b hit2=%b data2=%h want 0/%b/%h", fwd_hit1, fwd_hit2,
               fwd_data2, exp_hit, exp_data);
    end
    tick();
    checks++;
    if ({fwd_hit2, fwd_data2} !== {exp_hit, exp_data}) begin
      errors++;
      $display("FAIL fwd_head_only got hit=%b data=%h want %b/%h", fwd_hit2, fwd_data2, exp_hit,
               exp_data);
    end
    tick();
    checks++;
    if ({fwd_hit2, empty} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL fwd_after_drain got hit=%b empty=%b want 0/1", fwd_hit2, empty);
    end
    fwd_raddr1 = 5'd0;
    fwd_raddr2 = 5'd0;
  endtask

  task automatic test_reset_mid();
    pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h21;
    lng_valid = 1'b1; lng_waddr = 5'd2; lng_wdata = 32'h22;
    tick();
    pipe_waddr = 5'd3; pipe_wdata = 32'h23;
    lng_waddr = 5'd4; lng_wdata = 32'h24;
    tick();
    idle_inputs();
    checks++;
    if ({we, waddr, stall_req} !== {1'b1, 5'd2, 1'b1}) begin
      errors++;
      $display("FAIL mid_loaded got we=%b waddr=%0d stall=%b want 1/2/1", we, waddr, stall_req);
    end
    rst = 1'b1;
    lng_valid = 1'b1; lng_waddr = 5'd5; lng_wdata = 32'h25;
    #1;
    checks++;
    if ({we, empty, stall_req, lng_ready} !== 4'b0100) begin
      errors++;
      $display("FAIL mid_in_reset got we=%b empty=%b stall=%b ready=%b want 0/1/0/0", we, empty,
               stall_req, lng_ready);
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({we, empty, waddr, wdata} !== {1'b0, 1'b1, 5'd0, 32'd0}) begin
        errors++;
        $display("FAIL mid_stale%0d got we=%b empty=%b waddr=%0d wdata=%h want 0/1/0/0", i, we,
                 empty, waddr, wdata);
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    rst        = 1'b1;
    fwd_raddr1 = '0;
    fwd_raddr2 = '0;
    test_reset();
    test_single();
    test_dual();
    test_filter();
    test_full();
    test_fwd();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
